axis_y_reorder: RTL and testbench
=================================

# axis_y_reorder

Output-side companion of `axis_sa`: consumes the systolic array's result stream (one beat per column of Y, R row values per beat, last column first) and re-emits Y row-major (one beat per row, C column values per beat, column 0 in the lowest lane). A two-bank ping-pong buffer lets one matrix fill while the previous one drains, so the array is not stalled in steady state. The block sits between `axis_sa.m_*` and the downstream AXI-Stream sink.

## Interface
- `R`, default 2: rows of Y, lanes per input beat.
- `C`, default 2: columns of Y, lanes per output beat.
- `WY`, default 11: result word width, equal to `axis_sa` WY. Words pass through unmodified.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset; synchronous, active-high, one clock.
- `s_valid`  in  1  input beat valid.
- `s_ready`  out  1  input beat accepted when `s_valid && s_ready`.
- `s_data`  in  R*WY  lane r = Y[r][col] for the current column.
- `s_last`  in  1  marks the final column (column 0) of a matrix.
- `m_valid`  out  1  output beat valid.
- `m_ready`  in  1  downstream accepts.
- `m_data`  out  C*WY  lane c = Y[row][c].
- `m_last`  out  1  high on the row R-1 beat.
- `err_last`  out  1  one-cycle pulse on an s_last framing mismatch.

## Operation
- Two banks of R×C words each. Each bank has a `full` flag. Pointers: `wr_sel` and `rd_sel` (1 bit each), `wr_cnt` (0..C-1), `rd_cnt` (0..R-1).
- Per-bank state: EMPTY → FILLING (first beat accepted) → FULL (C-th beat accepted) → DRAINING (first output beat accepted) → EMPTY (R-th beat accepted).
- Write path:
  - `s_ready = !full[wr_sel]`.
  - On an accepted beat, lane r is written to bank[wr_sel][r][C-1-wr_cnt].
  - On wr_cnt = C-1: set `full[wr_sel]`, clear `wr_cnt`, toggle `wr_sel`.
- Framing:
  - Matrix boundaries are set by the beat count only.
  - `err_last` pulses when an accepted beat has `s_last != (wr_cnt == C-1)`. Data is still stored and counting is unaffected.
- Read path:
  - `m_valid = full[rd_sel]`.
  - `m_data` is row `rd_cnt` of bank[rd_sel].
  - `m_last = m_valid && rd_cnt == R-1`.
  - On an accepted beat with rd_cnt = R-1: clear `full[rd_sel]`, clear `rd_cnt`, toggle `rd_sel`.
- Simultaneous events:
  - The fill-complete of one bank and the drain-complete of the other in the same cycle both take effect.
  - The write and read banks are never the same bank while that bank is FULL, so no read/write collision is possible.
- Once `m_valid` is asserted, `m_data` and `m_last` stay stable until accepted (AXI-Stream rule).

## Timing
- Reset values:
  - `s_ready` = 0 while `rst` is high, and 1 in the first cycle after `rst` deasserts.
  - `m_valid`, `m_last`, `err_last` = 0.
  - `m_data` = 0 (banks cleared).
  - Counters, `wr_sel`, `rd_sel` and `full` = 0.
- Latency: `m_valid` rises in the cycle after the handshake of the C-th input beat. Row 0 is then presented immediately.
- Throughput:
  - With `m_ready` held at 1: C input cycles plus R output cycles per matrix, overlapped across the two banks.
  - When both banks are FULL, `s_ready` is 0 until a drain completes. `s_ready` rises the cycle after the last output handshake.
- Reset mid-operation: all partially filled or draining matrices are discarded, and the block restarts at bank 0 with empty buffers.
- `m_ready` low: `rd_cnt` and the output beat hold. Filling of the other bank continues.

## Test plan
- Basic (R=C=2, Y=[[1,2],[3,4]]): input beats {lane1=4, lane0=2}, then {lane1=3, lane0=1, s_last} → output {c1=2, c0=1}, then {c1=4, c0=3, m_last}. `m_valid` rises exactly 1 cycle after the second input handshake.
- Back-to-back, 50 random matrices, `m_ready` = 1: outputs match the row-major reference. `s_ready` never drops after the first two cycles.
- Backpressure: hold `m_ready` = 0 while 3 matrices are offered → exactly 2C beats accepted and then `s_ready` = 0. Release `m_ready` → outputs arrive in order and `s_ready` returns the cycle after the first drain completes.
- Framing error: assert `s_last` on the first beat of a matrix → `err_last` pulses 1 cycle and the output data is still correct row-major.
- Reset mid-drain: assert `rst` after output row 0 → next cycle `m_valid` = 0. A new matrix then produces the correct output starting from bank 0.
- Randomized valid/ready at 50% each: compare the full output stream against the reference model. Check that `m_data` and `m_last` are stable while `m_valid && !m_ready`.

Source files
------------

// File: rtl/axis_y_reorder.sv
// Column-major to row-major reorder buffer for the systolic array result stream.
// Two ping-pong banks let one matrix fill while the previous one drains.
module axis_y_reorder #(
    parameter int R  = 2,
    parameter int C  = 2,
    parameter int WY = 11
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [R*WY-1:0] s_data,
    input  logic            s_last,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [C*WY-1:0] m_data,
    output logic            m_last,
    output logic            err_last
);

    // Handshakes: a beat moves on a rising edge where valid && ready. m_valid
    // and the presented row depend only on registered state, so they hold until
    // accepted; s_ready depends only on registered state and rst.
    localparam int CW = (C > 1) ? $clog2(C) : 1;
    localparam int RW = (R > 1) ? $clog2(R) : 1;
    localparam logic [CW-1:0] WR_LAST = CW'(C - 1);
    localparam logic [RW-1:0] RD_LAST = RW'(R - 1);

    logic [WY-1:0] mem_q [2][R][C];

    logic [1:0]    full_q, full_d;
    logic          wr_sel_q, wr_sel_d;
    logic          rd_sel_q, rd_sel_d;
    logic [CW-1:0] wr_cnt_q, wr_cnt_d;
    logic [RW-1:0] rd_cnt_q, rd_cnt_d;
    logic          err_q, err_d;

    logic          s_fire;
    logic          m_fire;
    logic          wr_wrap;
    logic          rd_wrap;
    logic [CW-1:0] wr_col;

    assign s_ready  = !rst && !full_q[wr_sel_q];
    assign s_fire   = s_valid && s_ready;
    assign m_valid  = full_q[rd_sel_q];
    assign m_fire   = m_valid && m_ready;
    assign wr_wrap  = (wr_cnt_q == WR_LAST);
    assign rd_wrap  = (rd_cnt_q == RD_LAST);
    // The array emits the last column first.
    assign wr_col   = WR_LAST - wr_cnt_q;
    assign m_last   = m_valid && rd_wrap;
    assign err_last = err_q;

    always_comb begin
        m_data = '0;
        for (int c = 0; c < C; c++) begin
            m_data[c*WY +: WY] = mem_q[rd_sel_q][rd_cnt_q][c];
        end
    end

    // A bank completing its fill and the other bank completing its drain in the
    // same cycle touch different full bits, so both updates apply.
    always_comb begin
        full_d   = full_q;
        wr_sel_d = wr_sel_q;
        rd_sel_d = rd_sel_q;
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        err_d    = 1'b0;
        if (s_fire) begin
            err_d = (s_last != wr_wrap);
            if (wr_wrap) begin
                wr_cnt_d         = '0;
                wr_sel_d         = !wr_sel_q;
                full_d[wr_sel_q] = 1'b1;
            end else begin
                wr_cnt_d = wr_cnt_q + 1'b1;
            end
        end
        if (m_fire) begin
            if (rd_wrap) begin
                rd_cnt_d         = '0;
                rd_sel_d         = !rd_sel_q;
                full_d[rd_sel_q] = 1'b0;
            end else begin
                rd_cnt_d = rd_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q   <= '0;
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            full_q   <= full_d;
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < R; r++) begin
                    for (int c = 0; c < C; c++) begin
                        mem_q[b][r][c] <= '0;
                    end
                end
            end
        end else if (s_fire) begin
            for (int r = 0; r < R; r++) begin
                mem_q[wr_sel_q][r][wr_col] <= s_data[r*WY +: WY];
            end
        end
    end

endmodule

// File: tb/tb_axis_y_reorder.sv
// Self-checking bench for axis_y_reorder: column beats in, row beats checked
// against a row-major reference held in an expected queue.
module tb_axis_y_reorder;

    localparam int R  = 2;
    localparam int C  = 2;
    localparam int WY = 11;
    localparam int IW = R * WY;
    localparam int OW = C * WY;

    logic          clk;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [IW-1:0] s_data;
    logic          s_last;
    logic          m_valid;
    logic          m_ready;
    logic [OW-1:0] m_data;
    logic          m_last;
    logic          err_last;

    logic [IW:0] in_q [$];
    logic [OW:0] exp_q [$];
    int n_cmp;
    int n_err;

    axis_y_reorder #(.R(R), .C(C), .WY(WY)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_last   (m_last),
        .err_last (err_last)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // ---------------- stimulus generation ----------------
    // Random matrix: C column beats (last column first) into in_q, R rows into exp_q.
    task automatic push_matrix(input bit bad_first);
        logic [WY-1:0] y [R][C];
        logic [IW-1:0] din;
        logic [OW-1:0] dout;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                y[r][c] = WY'($urandom);
        for (int col = C - 1; col >= 0; col--) begin
            din = '0;
            for (int r = 0; r < R; r++) din[r*WY +: WY] = y[r][col];
            in_q.push_back({(col == 0) || (bad_first && col == C - 1), din});
        end
        for (int r = 0; r < R; r++) begin
            dout = '0;
            for (int c = 0; c < C; c++) dout[c*WY +: WY] = y[r][c];
            exp_q.push_back({r == R - 1, dout});
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_in(input int pct, input int budget, output int drops);
        bit fire;
        int cyc;
        drops = 0;
        cyc = 0;
        while (in_q.size() > 0 && cyc < budget) begin
            s_valid = ($urandom_range(1, 100) <= pct);
            s_last  = in_q[0][IW];
            s_data  = in_q[0][IW-1:0];
            @(negedge clk);
            if (!s_ready) drops++;
            fire = s_valid && s_ready;
            @(posedge clk);
            #1;
            if (fire) void'(in_q.pop_front());
            cyc++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        n_cmp++;
        if (in_q.size() != 0) begin
            n_err++;
            $display("FAIL drive_timeout: %0d beats left, required 0", in_q.size());
        end
    endtask

    task automatic recv(input int pct, input int n, input int budget);
        logic [OW:0]   e;
        logic [OW-1:0] hold_d;
        logic          hold_l;
        bit stall;
        int got;
        int cyc;
        got = 0;
        cyc = 0;
        stall = 0;
        hold_d = '0;
        hold_l = 1'b0;
        while (got < n && cyc < budget) begin
            m_ready = ($urandom_range(1, 100) <= pct);
            @(negedge clk);
            if (stall) begin
                n_cmp++;
                if (m_valid !== 1'b1 || m_data !== hold_d || m_last !== hold_l) begin
                    n_err++;
                    $display("FAIL stable: valid=%b data=%h last=%b, required 1 %h %b",
                             m_valid, m_data, m_last, hold_d, hold_l);
                end
            end
            if (m_valid && m_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_beat: data=%h, required none", m_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({m_last, m_data} !== e) begin
                        n_err++;
                        $display("FAIL out_beat: got last=%b data=%h, required last=%b data=%h",
                                 m_last, m_data, e[OW], e[OW-1:0]);
                    end
                end
                got++;
            end
            stall  = m_valid && !m_ready;
            hold_d = m_data;
            hold_l = m_last;
            @(posedge clk);
            #1;
            cyc++;
        end
        m_ready = 1'b0;
        n_cmp++;
        if (got != n) begin
            n_err++;
            $display("FAIL recv_timeout: got %0d beats, required %0d", got, n);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (s_ready !== 1'b0 || m_valid !== 1'b0 || m_last !== 1'b0 ||
            err_last !== 1'b0 || m_data !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: rdy=%b v=%b l=%b e=%b d=%h, required 0 0 0 0 0",
                     s_ready, m_valid, m_last, err_last, m_data);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (s_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready: s_ready=%b, required 1", s_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [OW:0] e;
        exp_q.push_back({1'b0, 11'd2, 11'd1});
        exp_q.push_back({1'b1, 11'd4, 11'd3});
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_data  = {11'd4, 11'd2};
        s_last  = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
            n_err++;
            $display("FAIL basic_beat0: rdy=%b v=%b, required 1 0", s_ready, m_valid);
        end
        @(posedge clk);
        #1;
        s_data = {11'd3, 11'd1};
        s_last = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (m_valid !== 1'b0) begin
            n_err++;
            $display("FAIL basic_early_valid: m_valid=%b, required 0", m_valid);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        for (int r = 0; r < R; r++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (m_valid !== 1'b1 || {m_last, m_data} !== e) begin
                n_err++;
                $display("FAIL basic_row%0d: v=%b last=%b data=%h, required 1 %b %h",
                         r, m_valid, m_last, m_data, e[OW], e[OW-1:0]);
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        n_cmp++;
        if (m_valid !== 1'b0 || err_last !== 1'b0) begin
            n_err++;
            $display("FAIL basic_done: v=%b err=%b, required 0 0", m_valid, err_last);
        end
        m_ready = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int drops;
        for (int i = 0; i < 50; i++) push_matrix(1'b0);
        fork
            drive_in(100, 1000, drops);
            recv(100, 50 * R, 1000);
        join
        n_cmp++;
        if (drops != 0) begin
            n_err++;
            $display("FAIL b2b_ready_drop: %0d cycles with s_ready low, required 0", drops);
        end
    endtask

    task automatic test_backpressure();
        logic [OW:0] e;
        int fires;
        int drops;
        int rem;
        bit fire;
        bit exp_rdy;
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_matrix(1'b0);
        fires = 0;
        for (int k = 0; k < 20; k++) begin
            s_valid = 1'b1;
            s_data  = in_q[0][IW-1:0];
            s_last  = in_q[0][IW];
            @(negedge clk);
            fire = s_ready;
            @(posedge clk);
            #1;
            if (fire) begin
                void'(in_q.pop_front());
                fires++;
            end
        end
        @(negedge clk);
        n_cmp++;
        if (fires != 2 * C || s_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_accept: %0d beats rdy=%b, required %0d beats rdy=0",
                     fires, s_ready, 2 * C);
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        for (int k = 0; k <= R; k++) begin
            s_data  = in_q[0][IW-1:0];
            s_last  = in_q[0][IW];
            exp_rdy = (k == R);
            @(negedge clk);
            n_cmp++;
            if (s_ready !== exp_rdy) begin
                n_err++;
                $display("FAIL bp_ready_k%0d: s_ready=%b, required %b", k, s_ready, exp_rdy);
            end
            if (m_valid && m_ready) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({m_last, m_data} !== e) begin
                    n_err++;
                    $display("FAIL bp_out: last=%b data=%h, required %b %h",
                             m_last, m_data, e[OW], e[OW-1:0]);
                end
            end
            fire = s_valid && s_ready;
            @(posedge clk);
            #1;
            if (fire) void'(in_q.pop_front());
        end
        s_valid = 1'b0;
        rem = exp_q.size();
        fork
            drive_in(100, 200, drops);
            recv(100, rem, 200);
        join
    endtask

    task automatic test_framing();
        push_matrix(1'b1);
        m_ready = 1'b0;
        for (int b = 0; b < C; b++) begin
            s_valid = 1'b1;
            s_data  = in_q[0][IW-1:0];
            s_last  = in_q[0][IW];
            @(negedge clk);
            n_cmp++;
            if (s_ready !== 1'b1) begin
                n_err++;
                $display("FAIL frame_ready%0d: s_ready=%b, required 1", b, s_ready);
            end
            @(posedge clk);
            #1;
            void'(in_q.pop_front());
            n_cmp++;
            if (err_last !== (b == 0)) begin
                n_err++;
                $display("FAIL frame_err%0d: err_last=%b, required %b", b, err_last, b == 0);
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        recv(100, R, 50);
    endtask

    task automatic test_reset_mid_drain();
        logic [OW:0] e;
        int drops;
        m_ready = 1'b0;
        push_matrix(1'b0);
        drive_in(100, 50, drops);
        // Partial fill of the other bank; must be discarded by the reset.
        s_valid = 1'b1;
        s_data  = IW'($urandom);
        s_last  = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (s_ready !== 1'b1) begin
            n_err++;
            $display("FAIL mid_partial: s_ready=%b, required 1", s_ready);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++;
        if (m_valid !== 1'b1 || {m_last, m_data} !== e) begin
            n_err++;
            $display("FAIL mid_row0: v=%b last=%b data=%h, required 1 %b %h",
                     m_valid, m_last, m_data, e[OW], e[OW-1:0]);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        m_ready = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (m_valid !== 1'b0 || m_last !== 1'b0 || s_ready !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset: v=%b l=%b rdy=%b, required 0 0 0", m_valid, m_last, s_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
            n_err++;
            $display("FAIL mid_restart: rdy=%b v=%b, required 1 0", s_ready, m_valid);
        end
        @(posedge clk);
        #1;
        exp_q.delete();
        push_matrix(1'b0);
        fork
            drive_in(100, 50, drops);
            recv(100, R, 50);
        join
    endtask

    task automatic test_random();
        int drops;
        for (int i = 0; i < 20; i++) push_matrix(1'b0);
        fork
            drive_in(50, 2000, drops);
            recv(50, 20 * R, 2000);
        join
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL rand_leftover: %0d rows pending, required 0", exp_q.size());
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_cmp   = 0;
        n_err   = 0;
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        m_ready = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_framing();
        test_reset_mid_drain();
        do_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
